// File: rtl/stream_esdes_decrypt_pkg.sv
// Shared widths and FSM encoding for the SDES output-feedback stream decryptor.
package stream_esdes_decrypt_pkg;

  localparam int BYTE_W = 8;
  localparam int KEY_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PRIME = 2'd2,
    RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/stream_esdes_decrypt_sdes.sv
// Combinational SDES block encryption of one byte under a 10-bit key.
// Two Feistel rounds with subkeys K1/K2 derived from the key by P10, rotations and P8.
module stream_esdes_decrypt_sdes
  import stream_esdes_decrypt_pkg::*;
(
  input  logic [BYTE_W-1:0] din,
  input  logic [KEY_W-1:0]  key,
  output logic [BYTE_W-1:0] dout
);

  // P8 selection from the rotated 10-bit key halves
  function automatic logic [7:0] p8(input logic [9:0] v);
    return {v[4], v[7], v[3], v[6], v[2], v[5], v[0], v[1]};
  endfunction

  // Initial permutation
  function automatic logic [7:0] ip(input logic [7:0] b);
    return {b[6], b[2], b[5], b[7], b[4], b[0], b[3], b[1]};
  endfunction

  // Inverse of the initial permutation
  function automatic logic [7:0] ip_inv(input logic [7:0] b);
    return {b[4], b[7], b[5], b[3], b[1], b[6], b[0], b[2]};
  endfunction

  // S-box S0, indexed by {row, col}
  function automatic logic [1:0] sbox0(input logic [3:0] rc);
    logic [1:0] s;
    case (rc)
      4'd0:  s = 2'd1;  4'd1:  s = 2'd0;  4'd2:  s = 2'd3;  4'd3:  s = 2'd2;
      4'd4:  s = 2'd3;  4'd5:  s = 2'd2;  4'd6:  s = 2'd1;  4'd7:  s = 2'd0;
      4'd8:  s = 2'd0;  4'd9:  s = 2'd2;  4'd10: s = 2'd1;  4'd11: s = 2'd3;
      4'd12: s = 2'd3;  4'd13: s = 2'd1;  4'd14: s = 2'd3;  default: s = 2'd2;
    endcase
    return s;
  endfunction

  // S-box S1, indexed by {row, col}
  function automatic logic [1:0] sbox1(input logic [3:0] rc);
    logic [1:0] s;
    case (rc)
      4'd0:  s = 2'd0;  4'd1:  s = 2'd1;  4'd2:  s = 2'd2;  4'd3:  s = 2'd3;
      4'd4:  s = 2'd2;  4'd5:  s = 2'd0;  4'd6:  s = 2'd1;  4'd7:  s = 2'd3;
      4'd8:  s = 2'd3;  4'd9:  s = 2'd0;  4'd10: s = 2'd1;  4'd11: s = 2'd0;
      4'd12: s = 2'd2;  4'd13: s = 2'd1;  4'd14: s = 2'd0;  default: s = 2'd3;
    endcase
    return s;
  endfunction

  // Round function: expand/permute, mix subkey, S-boxes, P4
  function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] sk);
    logic [7:0] x;
    logic [3:0] s;
    x = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ sk;
    s = {sbox0({x[7], x[4], x[6], x[5]}), sbox1({x[3], x[0], x[2], x[1]})};
    return {s[2], s[0], s[1], s[3]};
  endfunction

  logic [9:0] p10_key;
  logic [9:0] ls1_key;
  logic [9:0] ls3_key;
  logic [7:0] k1;
  logic [7:0] k2;
  logic [7:0] ip_out;
  logic [7:0] round1;
  logic [7:0] swapped;
  logic [7:0] round2;

  // Key schedule: P10, rotate halves by 1 for K1, by a further 2 for K2
  assign p10_key = {key[7], key[5], key[8], key[3], key[6], key[0], key[9], key[1], key[2], key[4]};
  assign ls1_key = {p10_key[8:5], p10_key[9], p10_key[3:0], p10_key[4]};
  assign ls3_key = {ls1_key[7:5], ls1_key[9:8], ls1_key[2:0], ls1_key[4:3]};
  assign k1      = p8(ls1_key);
  assign k2      = p8(ls3_key);

  // Data path: IP, fK(K1), swap, fK(K2), IP^-1
  assign ip_out  = ip(din);
  assign round1  = {ip_out[7:4] ^ f_round(ip_out[3:0], k1), ip_out[3:0]};
  assign swapped = {round1[3:0], round1[7:4]};
  assign round2  = {swapped[7:4] ^ f_round(swapped[3:0], k2), swapped[3:0]};
  assign dout    = ip_inv(round2);

endmodule

// File: rtl/stream_esdes_decrypt.sv
// SDES output-feedback stream decryptor: regenerates the keystream from the
// frame nonce/key and XORs one keystream byte onto each incoming ciphertext byte.
module stream_esdes_decrypt
  import stream_esdes_decrypt_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync,
  input  logic [BYTE_W-1:0] nonce,
  input  logic [KEY_W-1:0]  key,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_ZERO = '0;

  state_t            state_reg;
  state_t            state_next;
  logic [BYTE_W-1:0] nonce_reg;
  logic [KEY_W-1:0]  key_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic [BYTE_W-1:0] ks_reg;
  logic [BYTE_W-1:0] out_data_reg;
  logic              out_valid_reg;
  logic              out_last_reg;
  logic              done_reg;

  logic              load_frame;
  logic              in_fire;
  logic              last_byte;
  logic [BYTE_W-1:0] sdes_in;
  logic [BYTE_W-1:0] sdes_out;
  logic [BYTE_W-1:0] plain_byte;

  assign load_frame = (state_reg == IDLE) && sync;
  assign in_fire    = in_valid && in_ready;
  assign last_byte  = (cnt_reg == CNT_ONE);

  // PRIME seeds from the nonce; afterwards feed back the keystream, reseeding from the nonce on a zero state
  assign sdes_in = ((state_reg == PRIME) || (ks_reg == '0)) ? nonce_reg : ks_reg;

  stream_esdes_decrypt_sdes u_sdes (
    .din  (sdes_in),
    .key  (key_reg),
    .dout (sdes_out)
  );

  // Plaintext recovery, one bit lane per generate iteration
  genvar gi;
  generate
    for (gi = 0; gi < BYTE_W; gi++) begin : g_xor
      assign plain_byte[gi] = in_data[gi] ^ ks_reg[gi];
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state and handshake outputs; input accepted only in RUN when the output slot can take it
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (sync) state_next = LOAD;
      end
      LOAD: begin
        state_next = (cnt_reg != CNT_ZERO) ? PRIME : IDLE;
      end
      PRIME: begin
        state_next = RUN;
      end
      RUN: begin
        in_ready = !out_valid_reg || out_ready;
        if (in_valid && in_ready && last_byte) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Frame parameters captured on an accepted sync; byte countdown on each accepted input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonce_reg <= '0;
      key_reg   <= '0;
      cnt_reg   <= '0;
    end else if (load_frame) begin
      nonce_reg <= nonce;
      key_reg   <= key;
      cnt_reg   <= len;
    end else if (in_fire) begin
      cnt_reg <= cnt_reg - CNT_ONE;
    end
  end

  // Keystream register: K0 computed in PRIME, advanced once per consumed byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_reg <= '0;
    end else if ((state_reg == PRIME) || in_fire) begin
      ks_reg <= sdes_out;
    end
  end

  // Output register: load on input fire, clear on drain, hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (in_fire) begin
      out_data_reg  <= plain_byte;
      out_valid_reg <= 1'b1;
      out_last_reg  <= last_byte;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Frame-complete pulse: after the last input byte, or straight out of LOAD for an empty frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= ((state_reg == LOAD) && (cnt_reg == CNT_ZERO)) || (in_fire && last_byte);
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_stream_esdes_decrypt.sv
// Directed self-checking bench for stream_esdes_decrypt.
module tb_stream_esdes_decrypt;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sync;
  logic [7:0]       nonce;
  logic [9:0]       key;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ct_a  [0:15];
  logic [7:0] exp_a [0:15];
  logic [7:0] ks_a  [0:15];
  logic [7:0] pt_a  [0:15];
  logic [7:0] zero_nonce;
  logic       fired;

  // Reference SDES tables (positions numbered 1..N from the MSB)
  int p10_t [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  int p8_t  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  int ip_t  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  int ipi_t [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  int ep_t  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  int p4_t  [4]  = '{2, 4, 3, 1};
  int s0_t  [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int s1_t  [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  stream_esdes_decrypt #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync      (sync),
    .nonce     (nonce),
    .key       (key),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tb_p8(input logic [9:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[10-p8_t[i]];
    return r;
  endfunction

  function automatic logic [3:0] tb_f(input logic [3:0] r, input logic [7:0] sk);
    logic [7:0] x;
    logic [3:0] s;
    logic [3:0] o;
    int a;
    int b;
    for (int i = 0; i < 8; i++) x[7-i] = r[4-ep_t[i]];
    x = x ^ sk;
    a = s0_t[2*int'(x[7]) + int'(x[4])][2*int'(x[6]) + int'(x[5])];
    b = s1_t[2*int'(x[3]) + int'(x[0])][2*int'(x[2]) + int'(x[1])];
    s = 4'(a * 4 + b);
    for (int i = 0; i < 4; i++) o[3-i] = s[4-p4_t[i]];
    return o;
  endfunction

  function automatic logic [7:0] tb_sdes(input logic [7:0] p, input logic [9:0] k);
    logic [9:0] pk;
    logic [4:0] l;
    logic [4:0] r;
    logic [7:0] k1;
    logic [7:0] k2;
    logic [7:0] t;
    logic [7:0] u;
    for (int i = 0; i < 10; i++) pk[9-i] = k[10-p10_t[i]];
    l = pk[9:5];
    r = pk[4:0];
    l = (l << 1) | (l >> 4);
    r = (r << 1) | (r >> 4);
    k1 = tb_p8({l, r});
    l = (l << 2) | (l >> 3);
    r = (r << 2) | (r >> 3);
    k2 = tb_p8({l, r});
    for (int i = 0; i < 8; i++) t[7-i] = p[8-ip_t[i]];
    t = {t[7:4] ^ tb_f(t[3:0], k1), t[3:0]};
    t = {t[3:0], t[7:4]};
    t = {t[7:4] ^ tb_f(t[3:0], k2), t[3:0]};
    for (int i = 0; i < 8; i++) u[7-i] = t[8-ipi_t[i]];
    return u;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encryptor-side keystream for a frame
  task automatic gen_ks(input logic [7:0] n, input logic [9:0] k, input int cnt);
    logic [7:0] s;
    s = tb_sdes(n, k);
    for (int i = 0; i < cnt; i++) begin
      ks_a[i] = s;
      s = tb_sdes((s != 8'h00) ? s : n, k);
    end
  endtask

  // Plaintext in pt_a -> ciphertext ct_a, expected output exp_a = plaintext
  task automatic encrypt(input logic [7:0] n, input logic [9:0] k, input int cnt);
    gen_ks(n, k, cnt);
    for (int i = 0; i < cnt; i++) begin
      ct_a[i]  = pt_a[i] ^ ks_a[i];
      exp_a[i] = pt_a[i];
    end
  endtask

  // Streams ct_a into the DUT and checks every output byte against exp_a.
  // ready_mode 0: out_ready held high; 1: out_ready toggles 1,0,1,0...
  task automatic run_frame(input string tag, input logic [7:0] n, input logic [9:0] k, input int flen,
                           input int ready_mode, input bit issue_sync, input int abort_after,
                           input bit sync_mid);
    int  sent;
    int  got;
    int  cyc;
    int  done_cnt;
    int  done_cyc;
    int  last_fire_cyc;
    bit  mid_fired;
    bit  ifire;
    bit  ofire;
    sent = 0; got = 0; cyc = 0; done_cnt = 0; done_cyc = -1; last_fire_cyc = -1; mid_fired = 0;
    key = k;
    nonce = n;
    len = LEN_W'(flen);
    if (issue_sync) begin
      sync = 1'b1;
      tick();
      sync = 1'b0;
    end
    while ((got < flen || done_cnt == 0) && cyc < 200) begin
      sync = 1'b0;
      nonce = n;
      len = LEN_W'(flen);
      if (sync_mid && sent == 2 && !mid_fired) begin
        sync = 1'b1;
        nonce = ~n;
        len = LEN_W'(1);
        mid_fired = 1'b1;
      end
      in_valid = (sent < flen);
      in_data = (sent < flen) ? ct_a[sent] : 8'h00;
      out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      @(negedge clk);
      if (issue_sync && cyc < 2) chk($sformatf("%s_ready_low_load_prime", tag), in_ready, 1'b0);
      if (out_valid && !out_ready) chk($sformatf("%s_ready_stall%0d", tag, cyc), in_ready, 1'b0);
      ifire = in_valid && in_ready;
      ofire = out_valid && out_ready;
      if (ofire) begin
        chk($sformatf("%s_data%0d", tag, got), out_data, exp_a[got]);
        chk($sformatf("%s_last%0d", tag, got), out_last, (got == flen - 1));
        got++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ifire) begin
        sent++;
        last_fire_cyc = cyc;
      end
      tick();
      cyc++;
      if (abort_after > 0 && sent >= abort_after) break;
    end
    sync = 1'b0;
    in_valid = 1'b0;
    nonce = n;
    if (abort_after == 0) begin
      chk($sformatf("%s_bytes_out", tag), got, flen);
      chk($sformatf("%s_done_count", tag), done_cnt, 1);
      chk($sformatf("%s_done_timing", tag), done_cyc, last_fire_cyc + 1);
      @(negedge clk);
      chk($sformatf("%s_idle_busy", tag), busy, 1'b0);
      chk($sformatf("%s_idle_valid", tag), out_valid, 1'b0);
      chk($sformatf("%s_idle_done", tag), done, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; nonce = '0; key = '0; len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Hand-computed SDES vector: SDES(0x97, 0x282) = 0x38
    ct_a[0] = 8'h00; exp_a[0] = 8'h38;
    run_frame("hand0", 8'h97, 10'h282, 1, 0, 1'b1, 0, 1'b0);
    ct_a[0] = 8'hFF; exp_a[0] = 8'hC7;
    run_frame("hand1", 8'h97, 10'h282, 1, 0, 1'b1, 0, 1'b0);

    // Round trip through the encryptor model
    pt_a[0] = 8'h11; pt_a[1] = 8'h22; pt_a[2] = 8'h33; pt_a[3] = 8'h44;
    encrypt(8'hA5, 10'h282, 4);
    run_frame("roundtrip", 8'hA5, 10'h282, 4, 0, 1'b1, 0, 1'b0);

    // Golden keystream with all-zero key/nonce and zero ciphertext
    gen_ks(8'h00, 10'h000, 3);
    for (int i = 0; i < 3; i++) begin
      ct_a[i] = 8'h00;
      exp_a[i] = ks_a[i];
    end
    run_frame("golden", 8'h00, 10'h000, 3, 0, 1'b1, 0, 1'b0);

    // Zero keystream state on the very first byte forces a reseed from the nonce
    zero_nonce = 8'h00;
    for (int n = 0; n < 256; n++) begin
      if (tb_sdes(8'(n), 10'h282) == 8'h00) zero_nonce = 8'(n);
    end
    for (int i = 0; i < 4; i++) pt_a[i] = 8'h5A + 8'(i);
    encrypt(zero_nonce, 10'h282, 4);
    run_frame("reseed", zero_nonce, 10'h282, 4, 0, 1'b1, 0, 1'b0);

    // Backpressure: out_ready toggling, in_valid held high
    for (int i = 0; i < 8; i++) pt_a[i] = 8'(i * 17 + 1);
    encrypt(8'h3C, 10'h3FF, 8);
    run_frame("backpressure", 8'h3C, 10'h3FF, 8, 1, 1'b1, 0, 1'b0);

    // Empty frame: done one cycle after LOAD, no output
    nonce = 8'h12; key = 10'h0F0; len = '0;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    @(negedge clk);
    chk("empty_load_busy", busy, 1'b1);
    chk("empty_load_done", done, 1'b0);
    tick();
    @(negedge clk);
    chk("empty_done", done, 1'b1);
    chk("empty_busy", busy, 1'b0);
    chk("empty_valid", out_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("empty_done_clear", done, 1'b0);
    tick();

    // sync pulsed mid-frame with a different nonce/len is ignored
    for (int i = 0; i < 5; i++) pt_a[i] = 8'hA0 + 8'(i);
    encrypt(8'h81, 10'h155, 5);
    run_frame("syncmid", 8'h81, 10'h155, 5, 0, 1'b1, 0, 1'b1);

    // Reset mid-frame after byte 2 of 6 clears outputs asynchronously
    for (int i = 0; i < 6; i++) pt_a[i] = 8'hE0 ^ 8'(i);
    encrypt(8'h6D, 10'h2C3, 6);
    run_frame("prereset", 8'h6D, 10'h2C3, 6, 0, 1'b1, 2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, 8'h00);
    chk("arst_out_last", out_last, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_frame("postreset", 8'h6D, 10'h2C3, 6, 0, 1'b1, 0, 1'b0);

    // Back-to-back: frame A's last byte still pending when frame B is synced
    pt_a[0] = 8'h7E;
    encrypt(8'h42, 10'h0AB, 1);
    nonce = 8'h42; key = 10'h0AB; len = LEN_W'(1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    in_valid = 1'b1; in_data = ct_a[0]; out_ready = 1'b0;
    fired = 1'b0;
    for (int c = 0; c < 10 && !fired; c++) begin
      @(negedge clk);
      if (in_ready) fired = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_a_fire", fired, 1'b1);
    @(negedge clk);
    chk("b2b_a_valid", out_valid, 1'b1);
    chk("b2b_a_data", out_data, 8'h7E);
    chk("b2b_a_last", out_last, 1'b1);
    chk("b2b_a_done", done, 1'b1);
    tick();
    pt_a[0] = 8'hC1; pt_a[1] = 8'hC2; pt_a[2] = 8'hC3;
    encrypt(8'h43, 10'h0AB, 3);
    nonce = 8'h43; len = LEN_W'(3);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_hold_valid%0d", c), out_valid, 1'b1);
      chk($sformatf("b2b_hold_data%0d", c), out_data, 8'h7E);
      chk($sformatf("b2b_hold_ready%0d", c), in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_drain_valid", out_valid, 1'b1);
    chk("b2b_drain_data", out_data, 8'h7E);
    tick();
    run_frame("b2b_frame_b", 8'h43, 10'h0AB, 3, 0, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
